// File: rtl/lfsr_checker_if.sv
// Bus between an LFSR word source and lfsr_checker.
// The source drives the received word stream and the counter clear.
// The checker returns its lock status, error pulse, error count and debug state.
interface lfsr_checker_if #(
  parameter int N     = 4,
  parameter int ERR_W = 16
);

  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  // Word source / test harness side
  modport master (
    output in_valid,
    output in_data,
    output clear_cnt,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  state
  );

  // Checker side
  modport slave (
    input  in_valid,
    input  in_data,
    input  clear_cnt,
    output locked,
    output err_pulse,
    output err_count,
    output state
  );

endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for a parallel Fibonacci LFSR word stream.
//
// HUNT   : wait for a non-zero word to seed the local predictor.
// VERIFY : each word is compared with f(previous word). A run of LOCK_COUNT
//          matches enters LOCKED. A mismatch reseeds from the received word,
//          and a zero word drops back to HUNT.
// LOCKED : the predictor free-runs from its own output. A corrupted word
//          therefore costs exactly one error and does not disturb later
//          predictions. LOSS_COUNT consecutive misses return to HUNT.
//
// Errors are counted and pulsed only in LOCKED. The counter saturates and
// has a synchronous clear.
module lfsr_checker #(
  parameter int N          = 4,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  lfsr_checker_if.slave        bus
);

  // Each run counter is sized to hold its terminal count.
  localparam int RUN_W  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);

  // The counter value at which one more event completes the run.
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next word of the generator: shift left, feed back the XOR of the top two bits.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1] ^ x[N-2]};
  endfunction

  state_t             state_reg,     state_next;
  logic [N-1:0]       expected_reg,  expected_next;
  logic [RUN_W-1:0]   run_cnt_reg,   run_cnt_next;
  logic [MISS_W-1:0]  miss_cnt_reg,  miss_cnt_next;
  logic [ERR_W-1:0]   err_count_reg, err_count_next;
  logic               err_pulse_reg, err_pulse_next;

  // A received word that disagrees with the predictor.
  logic               word_miss;
  // A counted error: a miss on an accepted word while LOCKED.
  logic               err_hit;
  logic               in_zero;

  assign in_zero   = (bus.in_data == '0);
  assign word_miss = (bus.in_data != expected_reg);
  assign err_hit   = bus.in_valid && (state_reg == LOCKED) && word_miss;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= HUNT;
      expected_reg  <= '0;
      run_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      expected_reg  <= expected_next;
      run_cnt_reg   <= run_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  // Next-state and predictor update. Everything holds while in_valid is low.
  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    run_cnt_next  = run_cnt_reg;
    miss_cnt_next = miss_cnt_reg;

    if (bus.in_valid) begin
      case (state_reg)
        HUNT: begin
          // Zero is the generator's lock-up word and cannot seed the predictor.
          if (!in_zero) begin
            expected_next = lfsr_step(bus.in_data);
            run_cnt_next  = '0;
            state_next    = VERIFY;
          end
        end

        VERIFY: begin
          // Predictions follow the received stream until lock is declared.
          expected_next = lfsr_step(bus.in_data);
          if (!word_miss) begin
            run_cnt_next = run_cnt_reg + 1'b1;
            if (run_cnt_reg == RUN_LAST) begin
              state_next    = LOCKED;
              miss_cnt_next = '0;
            end
          end else begin
            run_cnt_next = '0;
            if (in_zero) begin
              state_next = HUNT;
            end
          end
        end

        LOCKED: begin
          // The predictor free-runs here, so a bad word cannot corrupt it.
          expected_next = lfsr_step(expected_reg);
          if (!word_miss) begin
            miss_cnt_next = '0;
          end else begin
            miss_cnt_next = miss_cnt_reg + 1'b1;
            if (miss_cnt_reg == MISS_LAST) begin
              state_next   = HUNT;
              run_cnt_next = '0;
            end
          end
        end

        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  // Error pulse and the saturating error counter with synchronous clear.
  always_comb begin
    err_pulse_next = err_hit;
    err_count_next = err_count_reg;
    if (bus.clear_cnt) begin
      // An error in the same cycle as the clear is kept as the new first count.
      err_count_next = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && !(&err_count_reg)) begin
      err_count_next = err_count_reg + 1'b1;
    end
  end

  // Output decode. Every output comes straight from a register.
  always_comb begin
    bus.locked    = (state_reg == LOCKED);
    bus.state     = state_reg;
    bus.err_pulse = err_pulse_reg;
    bus.err_count = err_count_reg;
  end

endmodule
